// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared definitions for the multi-cycle RV32I core: opcode
//            constants, access-width codes, FSM state and ALU operation
//            encodings, plus the funct3 -> ALU operation decoder.
// Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Data-port access sizes
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // alt selects SUB (for funct3=000) or SRA (for funct3=101). The caller
  // decides whether instr[30] is meaningful for the given opcode.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module   : cpu_alu
// Purpose  : Combinational RV32I ALU with comparison flags for branches.
// Ports    : a, b    - operands
//            op      - ALU operation
//            result  - operation result (wraps modulo 2^32)
//            eq      - a == b
//            lt      - a <  b signed
//            ltu     - a <  b unsigned
// Revision : 1.0  initial release
// ============================================================================
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  logic [4:0] shamt;

  assign shamt = b[4:0];
  assign eq    = (a == b);
  assign lt    = ($signed(a) < $signed(b));
  assign ltu   = (a < b);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {31'b0, lt};
      ALU_SLTU: result = {31'b0, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : cpu_core
// Purpose  : Multi-cycle RV32I core (FETCH -> EXEC [-> LOAD]). CPI is 2,
//            loads take 3. Register file and immediate generator are inline.
// Ports    : clk, rst_n            - clock, async active-low reset
//            instruction           - fetched word, valid in EXEC
//            address_instruction   - PC
//            data_in               - load data, right-aligned, valid in LOAD
//            data_out              - store data, right-aligned
//            address_data          - load/store byte address
//            width                 - 00 byte, 01 half, 10 word
//            write_mem             - store strobe (EXEC of a store only)
// Revision : 1.0  initial release
// ============================================================================
module cpu_core
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] address_instruction,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [31:0] address_data,
  output logic [1:0]  width,
  output logic        write_mem
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dout_q, dout_d;
  logic [1:0]  width_q, width_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [31:0] regs_q [0:31];

  // Register-file write port
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];

  // Reads see the pre-writeback value; x0 is hard-wired to zero.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // --------------------------------------------------------------------------
  // ALU operand selection. The ALU also forms load/store addresses and the
  // JALR target (rs1+imm), so only PC-relative targets need extra adders.
  // --------------------------------------------------------------------------
  logic [31:0] alu_a, alu_b, alu_result;
  alu_op_e     alu_op;
  logic        alu_eq, alu_lt, alu_ltu;

  always_comb begin
    alu_a  = rs1_val;
    alu_b  = imm_i;
    alu_op = ALU_ADD;
    case (opcode)
      OPC_LUI:    begin alu_a = 32'd0; alu_b = imm_u; end
      OPC_AUIPC:  begin alu_a = pc_q;  alu_b = imm_u; end
      OPC_STORE:  alu_b = imm_s;
      OPC_BRANCH: alu_b = rs2_val;
      OPC_OP:     begin
        alu_b  = rs2_val;
        alu_op = alu_decode(funct3, instruction[30]);
      end
      // For immediates instr[30] only matters for SRAI; for ADDI it is imm bit.
      OPC_OP_IMM: alu_op = alu_decode(funct3, (funct3 == 3'b101) && instruction[30]);
      default:    ;
    endcase
  end

  cpu_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .eq     (alu_eq),
    .lt     (alu_lt),
    .ltu    (alu_ltu)
  );

  logic [31:0] pc_plus4, br_target, jal_target, jalr_target;
  logic        br_taken;

  assign pc_plus4    = pc_q + 32'd4;
  assign br_target   = pc_q + imm_b;
  assign jal_target  = pc_q + imm_j;
  assign jalr_target = {alu_result[31:1], 1'b0};

  always_comb begin
    case (funct3)
      3'b000:  br_taken = alu_eq;
      3'b001:  br_taken = !alu_eq;
      3'b100:  br_taken = alu_lt;
      3'b101:  br_taken = !alu_lt;
      3'b110:  br_taken = alu_ltu;
      3'b111:  br_taken = !alu_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Load data extension uses the funct3 captured at the end of EXEC.
  logic [31:0] load_ext;

  always_comb begin
    case (ld_f3_q)
      3'b000:  load_ext = {{24{data_in[7]}}, data_in[7:0]};
      3'b001:  load_ext = {{16{data_in[15]}}, data_in[15:0]};
      3'b100:  load_ext = {24'b0, data_in[7:0]};
      3'b101:  load_ext = {16'b0, data_in[15:0]};
      default: load_ext = data_in;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic write_mem_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    width_d     = width_q;
    ld_rd_d     = ld_rd_q;
    ld_f3_d     = ld_f3_q;
    rf_we       = 1'b0;
    rf_waddr    = rd;
    rf_wdata    = alu_result;
    write_mem_d = 1'b0;

    case (state_q)
      ST_FETCH: state_d = ST_EXEC;

      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_plus4;
        case (opcode)
          OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: rf_we = 1'b1;
          OPC_JAL: begin
            rf_we    = 1'b1;
            rf_wdata = pc_plus4;
            pc_d     = jal_target;
          end
          OPC_JALR: begin
            rf_we    = 1'b1;
            rf_wdata = pc_plus4;
            pc_d     = jalr_target;
          end
          OPC_BRANCH: if (br_taken) pc_d = br_target;
          OPC_STORE: begin
            write_mem_d = 1'b1;
            addr_d      = alu_result;
            dout_d      = rs2_val;
            width_d     = funct3[1:0];
          end
          OPC_LOAD: begin
            // PC advances only when the load retires in LOAD.
            state_d = ST_LOAD;
            pc_d    = pc_q;
            addr_d  = alu_result;
            width_d = funct3[1:0];
            ld_rd_d = rd;
            ld_f3_d = funct3;
          end
          default: ;  // FENCE/SYSTEM/unknown: plain PC+4
        endcase
      end

      ST_LOAD: begin
        state_d  = ST_FETCH;
        pc_d     = pc_plus4;
        rf_we    = 1'b1;
        rf_waddr = ld_rd_q;
        rf_wdata = load_ext;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // The data port is driven from the next-value of the hold registers so the
  // EXEC-cycle address is visible immediately and then held through LOAD and
  // idle cycles.
  assign address_instruction = pc_q;
  assign address_data        = addr_d;
  assign data_out            = dout_d;
  assign width               = width_d;
  assign write_mem           = write_mem_d;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      dout_q  <= '0;
      width_q <= WIDTH_WORD;
      ld_rd_q <= '0;
      ld_f3_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      width_q <= width_d;
      ld_rd_q <= ld_rd_d;
      ld_f3_q <= ld_f3_d;
      if (rf_we && (rf_waddr != 5'd0)) regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_core
// Purpose  : Directed self-checking bench for cpu_core with a boot ROM and
//            byte-addressed data RAM. Register results are observed through
//            SW/SB instructions on the data port.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] address_instruction;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] address_data;
  logic [1:0]  width;
  logic        write_mem;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int at     = 0;

  logic [31:0] rom [0:255];
  logic [7:0]  ram [0:1023];
  logic [9:0]  wa;

  always #5 clk = ~clk;

  cpu_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instruction         (instruction),
    .address_instruction (address_instruction),
    .data_in             (data_in),
    .data_out            (data_out),
    .address_data        (address_data),
    .width               (width),
    .write_mem           (write_mem)
  );

  // ---------------- memory models ----------------
  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] w);
    logic [31:0] word;
    logic [9:0]  i;
    i = a[9:0];
    if (a[10]) word = {ram[i + 10'd3], ram[i + 10'd2], ram[i + 10'd1], ram[i]};
    else       word = rom[a[9:2]] >> {a[1:0], 3'b000};
    case (w)
      2'b00:   return {24'b0, word[7:0]};
      2'b01:   return {16'b0, word[15:0]};
      default: return word;
    endcase
  endfunction

  assign wa = address_data[9:0];

  always @(posedge clk) begin
    instruction <= rom[address_instruction[9:2]];
    data_in     <= mem_read(address_data, width);
    if (write_mem && address_data[10]) begin
      ram[wa] <= data_out[7:0];
      if (width != 2'b00) ram[wa + 10'd1] <= data_out[15:8];
      if (width == 2'b10) begin
        ram[wa + 10'd2] <= data_out[23:16];
        ram[wa + 10'd3] <= data_out[31:24];
      end
    end
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] pc);
    int n;
    n = 0;
    while (address_instruction !== pc && n < 200) begin
      tick();
      n++;
    end
    chk({tag, " reach pc"}, address_instruction, pc);
  endtask

  // Waits for the next store strobe, checks the bus, then checks the strobe
  // drops on the following cycle.
  task automatic wait_store(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] w);
    int n;
    n = 0;
    tick();
    while (write_mem !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    at = cyc;
    chk({tag, " strobe"}, {31'b0, write_mem}, 32'd1);
    if (write_mem === 1'b1) begin
      chk({tag, " pc"},    address_instruction, pc);
      chk({tag, " addr"},  address_data, addr);
      chk({tag, " data"},  data_out, data);
      chk({tag, " width"}, {30'b0, width}, {30'b0, w});
      tick();
      chk({tag, " strobe drop"}, {31'b0, write_mem}, 32'd0);
    end
  endtask

  // ---------------- program + stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    rom[8'h00] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OPI);          // ADDI x1,x0,5
    rom[8'h01] = enc_i(-32'sd3, 5'd0, 3'b000, 5'd2, OPI);        // ADDI x2,x0,-3
    rom[8'h02] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);         // ADD x3,x1,x2
    rom[8'h03] = enc_i(32'h400, 5'd0, 3'b000, 5'd4, OPI);        // ADDI x4,x0,0x400
    rom[8'h04] = enc_s(32'd8, 5'd4, 5'd3, 3'b010);               // SW x3,8(x4)
    rom[8'h05] = enc_i(32'h1A5, 5'd0, 3'b000, 5'd5, OPI);        // ADDI x5,x0,0x1A5
    rom[8'h06] = enc_s(32'd0, 5'd4, 5'd5, 3'b010);               // SW x5,0(x4)
    rom[8'h07] = enc_i(32'd0, 5'd4, 3'b010, 5'd6, LD);           // LW x6,0(x4)
    rom[8'h08] = enc_s(32'd4, 5'd4, 5'd6, 3'b010);               // SW x6,4(x4)
    rom[8'h09] = enc_i(-32'sd1, 5'd0, 3'b000, 5'd7, OPI);        // ADDI x7,x0,-1
    rom[8'h0A] = enc_s(32'd1, 5'd4, 5'd7, 3'b000);               // SB x7,1(x4)
    rom[8'h0B] = enc_i(32'd1, 5'd4, 3'b000, 5'd8, LD);           // LB x8,1(x4)
    rom[8'h0C] = enc_i(32'd1, 5'd4, 3'b100, 5'd9, LD);           // LBU x9,1(x4)
    rom[8'h0D] = enc_s(32'd12, 5'd4, 5'd8, 3'b010);              // SW x8,12(x4)
    rom[8'h0E] = enc_s(32'd16, 5'd4, 5'd9, 3'b010);              // SW x9,16(x4)
    rom[8'h0F] = enc_i(32'd7, 5'd0, 3'b000, 5'd0, OPI);          // ADDI x0,x0,7
    rom[8'h10] = enc_s(32'd20, 5'd4, 5'd0, 3'b010);              // SW x0,20(x4)
    rom[8'h11] = {20'h80000, 5'd10, 7'b0110111};                 // LUI x10,0x80000
    rom[8'h12] = enc_i(32'h404, 5'd10, 3'b101, 5'd11, OPI);      // SRAI x11,x10,4
    rom[8'h13] = enc_i(32'h004, 5'd10, 3'b101, 5'd12, OPI);      // SRLI x12,x10,4
    rom[8'h14] = enc_s(32'd24, 5'd4, 5'd11, 3'b010);             // SW x11,24(x4)
    rom[8'h15] = enc_s(32'd28, 5'd4, 5'd12, 3'b010);             // SW x12,28(x4)
    rom[8'h16] = enc_b(32'd8, 5'd1, 5'd1, 3'b000);               // 0x58 BEQ x1,x1,+8 (taken)
    rom[8'h17] = enc_i(32'd1, 5'd0, 3'b000, 5'd13, OPI);         // poison x13
    rom[8'h18] = enc_b(32'd8, 5'd1, 5'd3, 3'b000);               // 0x60 BEQ x1,x3 (not taken)
    rom[8'h19] = enc_b(32'd8, 5'd7, 5'd1, 3'b100);               // 0x64 BLT -1,5 (taken)
    rom[8'h1A] = enc_i(32'd1, 5'd0, 3'b000, 5'd13, OPI);         // poison x13
    rom[8'h1B] = enc_b(32'd8, 5'd7, 5'd1, 3'b110);               // 0x6C BLTU (not taken)
    rom[8'h1C] = enc_j(32'd8, 5'd1);                             // 0x70 JAL x1,+8
    rom[8'h1D] = enc_i(32'd1, 5'd0, 3'b000, 5'd13, OPI);         // poison x13
    rom[8'h1E] = enc_s(32'd32, 5'd4, 5'd1, 3'b010);              // 0x78 SW x1,32(x4)
    rom[8'h1F] = enc_i(32'h91, 5'd0, 3'b000, 5'd14, OPI);        // ADDI x14,x0,0x91
    rom[8'h20] = enc_i(32'd0, 5'd14, 3'b000, 5'd15, 7'b1100111); // 0x80 JALR x15,0(x14)
    rom[8'h21] = enc_i(32'd1, 5'd0, 3'b000, 5'd13, OPI);         // poison x13
    rom[8'h22] = enc_i(32'd1, 5'd0, 3'b000, 5'd13, OPI);
    rom[8'h23] = enc_i(32'd1, 5'd0, 3'b000, 5'd13, OPI);
    rom[8'h24] = enc_s(32'd36, 5'd4, 5'd15, 3'b010);             // 0x90 SW x15,36(x4)
    rom[8'h25] = enc_s(32'd40, 5'd4, 5'd13, 3'b010);             // 0x94 SW x13,40(x4)
    rom[8'h26] = enc_r(7'h20, 5'd3, 5'd1, 3'b000, 5'd16);        // SUB x16,x1,x3
    rom[8'h27] = enc_s(32'd44, 5'd4, 5'd16, 3'b010);             // 0x9C SW x16,44(x4)
    rom[8'h28] = enc_b(32'd0, 5'd0, 5'd0, 3'b000);               // 0xA0 self-loop

    instruction = '0;
    data_in     = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset pc",        address_instruction, 32'h0);
    chk("reset write_mem", {31'b0, write_mem}, 32'd0);
    chk("reset width",     {30'b0, width}, 32'd2);
    chk("reset addr",      address_data, 32'h0);
    chk("reset data_out",  data_out, 32'h0);

    rst_n = 1'b1;
    cyc   = 0;
    tick(); chk("cpi pc@1", address_instruction, 32'h0);
    tick(); chk("cpi pc@2", address_instruction, 32'h4);
    tick(); tick(); chk("cpi pc@4", address_instruction, 32'h8);

    wait_store("sw_add",  32'h10, 32'h408, 32'h2,   2'b10);
    chk("sw_add cycle", at, 9);
    wait_store("sw_x5",   32'h18, 32'h400, 32'h1A5, 2'b10);
    chk("sw_x5 cycle", at, 13);
    wait_store("sw_lw",   32'h20, 32'h404, 32'h1A5, 2'b10);
    chk("load cpi cycle", at, 18);
    wait_store("sb",      32'h28, 32'h401, 32'hFFFF_FFFF, 2'b00);
    wait_store("lb",      32'h34, 32'h40C, 32'hFFFF_FFFF, 2'b10);
    wait_store("lbu",     32'h38, 32'h410, 32'h0000_00FF, 2'b10);
    wait_store("x0",      32'h40, 32'h414, 32'h0,         2'b10);
    wait_store("srai",    32'h50, 32'h418, 32'hF800_0000, 2'b10);
    wait_store("srli",    32'h54, 32'h41C, 32'h0800_0000, 2'b10);
    wait_store("jal",     32'h78, 32'h420, 32'h74,        2'b10);
    wait_store("jalr",    32'h90, 32'h424, 32'h84,        2'b10);
    wait_store("skipped", 32'h94, 32'h428, 32'h0,         2'b10);
    wait_store("sub",     32'h9C, 32'h42C, 32'h72,        2'b10);

    wait_pc("selfloop", 32'hA0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("selfloop pc", address_instruction, 32'hA0);
      chk("selfloop write_mem", {31'b0, write_mem}, 32'd0);
    end

    // Restart, then assert reset while the LW at 0x1C is in LOAD.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    cyc   = 0;
    wait_pc("restart lw", 32'h1C);
    chk("restart lw cycle", cyc, 14);
    tick();
    chk("lw exec addr", address_data, 32'h400);
    tick();
    chk("lw load addr held", address_data, 32'h400);
    chk("lw load width", {30'b0, width}, 32'd2);
    chk("lw load pc", address_instruction, 32'h1C);
    chk("lw load write_mem", {31'b0, write_mem}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midload reset pc", address_instruction, 32'h0);
    chk("midload reset write_mem", {31'b0, write_mem}, 32'd0);
    chk("midload reset addr", address_data, 32'h0);
    tick();
    rst_n = 1'b1;
    cyc   = 0;
    chk("post reset pc", address_instruction, 32'h0);
    wait_store("post reset sw_add", 32'h10, 32'h408, 32'h2, 2'b10);
    chk("post reset sw_add cycle", at, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
